// File: rtl/fwrisc_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mem_arb_pkg
// Purpose  : Shared state encoding and constants for the fwrisc memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fwrisc_mem_arb_pkg;

    // Arbiter grant state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Read data returned to a requester whose transfer was aborted by the watchdog
    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/fwrisc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mem_arbiter_if
// Purpose  : Bundles the fetch port, data port and shared memory port.
//            slave  = arbiter view, master = core/memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface fwrisc_mem_arbiter_if;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        dwrite;
    logic        dvalid;
    logic        dready;
    logic [31:0] drdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mstrb;
    logic        mwrite;
    logic        mvalid;
    logic        mready;
    logic [31:0] mrdata;
    logic        merr;

    modport slave (
        input  iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid, mready, mrdata,
        output iready, idata, dready, drdata, maddr, mwdata, mstrb, mwrite, mvalid, merr
    );

    modport master (
        output iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid, mready, mrdata,
        input  iready, idata, dready, drdata, maddr, mwdata, mstrb, mwrite, mvalid, merr
    );
endinterface
`default_nettype wire

// File: rtl/fwrisc_mem_arb_wdt.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mem_arb_wdt
// Purpose  : Watchdog counting stalled granted cycles. expire is asserted in
//            the TIMEOUT_CYCLES-th counted cycle. TIMEOUT_CYCLES = 0 disables it.
// Revision : 1.0 - initial release
// ============================================================================
module fwrisc_mem_arb_wdt #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic count_en,
    output logic      expire
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdt_on
            localparam logic [TIMEOUT_W-1:0] c_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
            logic [TIMEOUT_W-1:0] r_count;

            // Count stalled cycles; cleared while no grant is active
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    r_count <= '0;
                end else if (count_en) begin
                    r_count <= r_count + TIMEOUT_W'(1);
                end
            end

            // Fires combinationally in the stalled cycle that reaches the limit
            assign expire = count_en && (r_count == c_last);
        end else begin : g_wdt_off
            logic w_unused;
            assign w_unused = &{1'b0, clock, reset, clear, count_en};
            assign expire   = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fwrisc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mem_arbiter
// Purpose  : Shares one memory port between the fwrisc fetch and data ports,
//            with a watchdog that aborts transfers stalled on mready.
//            Optional macro FWRISC_MEM_ARB_RR_EN selects round-robin
//            arbitration; otherwise the data port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module fwrisc_mem_arbiter
    import fwrisc_mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  wire logic            clock,
    input  wire logic            reset,
    fwrisc_mem_arbiter_if.slave  bus
);

    arb_state_e r_state;
    logic       w_req_valid;
    logic       w_done;
    logic       w_expire;
    logic       w_abort;
    logic       w_pick_d;

    // Valid of whichever requester currently owns the memory port
    assign w_req_valid = (r_state == GNT_I) ? bus.ivalid :
                         (r_state == GNT_D) ? bus.dvalid : 1'b0;
    assign w_done      = w_req_valid && bus.mready;
    assign w_abort     = w_expire && w_req_valid;

    fwrisc_mem_arb_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_wdt (
        .clock    (clock),
        .reset    (reset),
        .clear    (r_state == IDLE),
        .count_en ((r_state != IDLE) && !bus.mready),
        .expire   (w_expire)
    );

`ifdef FWRISC_MEM_ARB_RR_EN
    logic r_last_d;

    // Data wins a tie only if fetch was granted last
    assign w_pick_d = bus.dvalid && (!bus.ivalid || !r_last_d);

    // Remember which requester took the most recent grant
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && (bus.dvalid || bus.ivalid)) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = bus.dvalid;
`endif

    // Grant state machine: one IDLE cycle between every pair of transfers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d)        r_state <= GNT_D;
                    else if (bus.ivalid) r_state <= GNT_I;
                end
                GNT_I, GNT_D: begin
                    if (!w_req_valid || w_done || w_abort) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory-side mux and requester handshakes, all combinational from state
    always_comb begin
        bus.maddr  = 32'h0;
        bus.mwdata = 32'h0;
        bus.mstrb  = 4'h0;
        bus.mwrite = 1'b0;
        bus.mvalid = 1'b0;
        bus.iready = 1'b0;
        bus.dready = 1'b0;
        bus.merr   = 1'b0;
        bus.idata  = bus.mrdata;
        bus.drdata = bus.mrdata;
        case (r_state)
            GNT_I: begin
                bus.maddr  = bus.iaddr;
                bus.mstrb  = 4'hf;
                bus.mvalid = bus.ivalid && !w_expire;
                bus.iready = w_done || w_abort;
                bus.merr   = w_abort;
                if (w_abort) bus.idata = ARB_ABORT_DATA;
            end
            GNT_D: begin
                bus.maddr  = bus.daddr;
                bus.mwdata = bus.dwdata;
                bus.mstrb  = bus.dstrb;
                bus.mwrite = bus.dwrite;
                bus.mvalid = bus.dvalid && !w_expire;
                bus.dready = w_done || w_abort;
                bus.merr   = w_abort;
                if (w_abort) bus.drdata = ARB_ABORT_DATA;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
